// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// MEM/WB pipeline register and writeback logic for the MIPS datapath.
// Captures one retiring instruction per accepted handshake. It picks the ALU,
// load or link result and extracts and extends sub-word loads. It drives the
// register-file write port for exactly one cycle per instruction and never
// writes $0. It also provides a registered forwarding tap for the bypass unit
// and counts retired instructions.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   handshake from the MEM stage
//   in_reg_write, in_dest instruction writes GPR in_dest
//   in_wb_sel             00 ALU, 01 load, 10 link, 11 ALU
//   in_alu_result, in_mem_data, in_pc_plus4   candidate results
//   in_load_type          000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, else LW
//   in_byte_off           load address bits [1:0]
//   wb_hold, flush        downstream hold, kill of the held instruction
//   WriteRegister/WriteData/WriteEnable       register-file write port
//   fwd_valid/fwd_reg/fwd_data                bypass tap
//   align_err             pulse: misaligned halfword load retired
//   retire_count          instructions retired since reset
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [4:0]        in_dest,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_byte_off,
  input  logic              wb_hold,
  input  logic              flush,
  output logic [4:0]        WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEnable,
  output logic              fwd_valid,
  output logic [4:0]        fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              align_err,
  output logic [CNT_W-1:0]  retire_count
);

  // EMPTY: no instruction; FRESH: write being presented; HELD: written, waiting
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FRESH = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic [1:0]        state_q, state_d;
  logic              stage_valid_s;
  logic              accept_s;
  logic              wr_ok_s;
  logic              misalign_s;
  logic [DATA_W-1:0] wb_data_s;

  logic [4:0]        wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              fwd_ok_q;     // held instruction really writes a GPR
  logic              fwd_valid_q;
  logic              align_err_q;
  logic [CNT_W-1:0]  count_q;

  // Sub-word load extraction; the halfword lane comes from off[1] only, so a
  // misaligned LH/LHU still produces data.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [2:0]        lt,
    input logic [1:0]        off,
    input logic [DATA_W-1:0] mem
  );
    logic [15:0]       half_v;
    logic [7:0]        byte_v;
    logic [DATA_W-1:0] res_v;
    half_v = off[1] ? mem[31:16] : mem[15:0];
    case (off)
      2'd0:    byte_v = mem[7:0];
      2'd1:    byte_v = mem[15:8];
      2'd2:    byte_v = mem[23:16];
      2'd3:    byte_v = mem[31:24];
      default: byte_v = mem[7:0];
    endcase
    case (lt)
      LT_LH:   res_v = {{(DATA_W-16){half_v[15]}}, half_v};
      LT_LHU:  res_v = {{(DATA_W-16){1'b0}}, half_v};
      LT_LB:   res_v = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LT_LBU:  res_v = {{(DATA_W-8){1'b0}}, byte_v};
      default: res_v = mem;
    endcase
    return res_v;
  endfunction

  assign stage_valid_s = (state_q != ST_EMPTY);
  assign in_ready      = ~stage_valid_s | ~wb_hold;
  assign accept_s      = in_valid & in_ready & ~flush;
  assign wr_ok_s       = in_reg_write & (in_dest != 5'd0);
  assign misalign_s    = (in_wb_sel == SEL_LOAD) &
                         ((in_load_type == LT_LH) | (in_load_type == LT_LHU)) &
                         in_byte_off[0];

  // Writeback result select; 11 falls back to the ALU result
  always_comb begin
    wb_data_s = in_alu_result;
    case (in_wb_sel)
      SEL_LOAD: wb_data_s = load_extend(in_load_type, in_byte_off, in_mem_data);
      SEL_LINK: wb_data_s = in_pc_plus4;
      default:  wb_data_s = in_alu_result;
    endcase
  end

  // Next state: flush beats accept; a valid stage under hold parks in HELD
  always_comb begin
    state_d = ST_EMPTY;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept_s) begin
      state_d = ST_FRESH;
    end else if (stage_valid_s && wb_hold) begin
      state_d = ST_HELD;
    end else begin
      state_d = ST_EMPTY;
    end
  end

  // Pipeline register, one-shot write strobe, forwarding tap and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      wreg_q      <= 5'd0;
      wdata_q     <= {DATA_W{1'b0}};
      we_q        <= 1'b0;
      fwd_ok_q    <= 1'b0;
      fwd_valid_q <= 1'b0;
      align_err_q <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      // Only an accept enters FRESH, so the strobe and error pulse last one cycle
      we_q        <= accept_s & wr_ok_s;
      align_err_q <= accept_s & misalign_s;
      fwd_valid_q <= (state_d != ST_EMPTY) & (accept_s ? wr_ok_s : fwd_ok_q);
      if (accept_s) begin
        wreg_q   <= in_dest;
        wdata_q  <= wb_data_s;
        fwd_ok_q <= wr_ok_s;
        count_q  <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wreg_q   <= wreg_q;
        wdata_q  <= wdata_q;
        fwd_ok_q <= fwd_ok_q;
        count_q  <= count_q;
      end
    end
  end

  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign WriteEnable   = we_q;
  assign fwd_valid     = fwd_valid_q;
  assign fwd_reg       = wreg_q;
  assign fwd_data      = wdata_q;
  assign align_err     = align_err_q;
  assign retire_count  = count_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_reg_write;
  logic [4:0]  in_dest;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus4;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;
  logic        wb_hold, flush;
  logic [4:0]  WriteRegister, fwd_reg;
  logic [31:0] WriteData, fwd_data, retire_count;
  logic        WriteEnable, fwd_valid, align_err;

  int errors = 0;
  int checks = 0;
  int hc     = 0;   // hand-tracked number of accepted instructions
  int pulses;

  writeback_stage #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_dest(in_dest), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus4(in_pc_plus4), .in_load_type(in_load_type),
    .in_byte_off(in_byte_off), .wb_hold(wb_hold), .flush(flush),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .WriteEnable(WriteEnable), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_data(fwd_data), .align_err(align_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected result from the architectural load/select rules
  function automatic logic [31:0] exp_data(input logic [1:0] sel, input logic [2:0] lt,
                                           input logic [1:0] off, input logic [31:0] alu,
                                           input logic [31:0] mem, input logic [31:0] pc);
    logic [31:0] b, h;
    b = (mem >> (8 * off)) & 32'h0000_00FF;
    h = (mem >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
    if (sel == 2'b10) return pc;
    if (sel != 2'b01) return alu;
    case (lt)
      3'd1:    return (h ^ 32'h0000_8000) - 32'h0000_8000;
      3'd2:    return h;
      3'd3:    return (b ^ 32'h0000_0080) - 32'h0000_0080;
      3'd4:    return b;
      default: return mem;
    endcase
  endfunction

  // Transaction-level model: one retiring instruction with its age
  logic        m_valid, m_fresh, m_wr, m_aerr;
  logic [4:0]  m_dest;
  logic [31:0] m_data, m_cnt;
  wire m_acc = in_valid && (!m_valid || !wb_hold) && !flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_fresh <= 1'b0; m_wr <= 1'b0; m_aerr <= 1'b0;
      m_dest <= 5'd0; m_data <= 32'd0; m_cnt <= 32'd0;
    end else if (flush) begin
      m_valid <= 1'b0; m_fresh <= 1'b0;
    end else if (m_acc) begin
      m_valid <= 1'b1; m_fresh <= 1'b1;
      m_dest  <= in_dest;
      m_wr    <= in_reg_write && (in_dest != 5'd0);
      m_data  <= exp_data(in_wb_sel, in_load_type, in_byte_off,
                          in_alu_result, in_mem_data, in_pc_plus4);
      m_aerr  <= (in_wb_sel == 2'b01) && (in_load_type == 3'd1 || in_load_type == 3'd2)
                 && in_byte_off[0];
      m_cnt   <= m_cnt + 32'd1;
    end else if (m_valid && wb_hold) begin
      m_fresh <= 1'b0;
    end else begin
      m_valid <= 1'b0; m_fresh <= 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("cmp_we",     {31'd0, WriteEnable}, {31'd0, m_fresh && m_wr});
    chk("cmp_wreg",   {27'd0, WriteRegister}, {27'd0, m_dest});
    chk("cmp_wdata",  WriteData, m_data);
    chk("cmp_fwdv",   {31'd0, fwd_valid}, {31'd0, m_valid && m_wr});
    chk("cmp_fwdreg", {27'd0, fwd_reg}, {27'd0, m_dest});
    chk("cmp_fwdata", fwd_data, m_data);
    chk("cmp_aerr",   {31'd0, align_err}, {31'd0, m_fresh && m_aerr});
    chk("cmp_cnt",    retire_count, m_cnt);
    chk("cmp_ready",  {31'd0, in_ready}, {31'd0, !m_valid || !wb_hold});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic rw, input logic [4:0] d, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] mem);
    in_valid = 1'b1; in_reg_write = rw; in_dest = d; in_wb_sel = sel;
    in_load_type = lt; in_byte_off = off; in_alu_result = alu; in_mem_data = mem;
  endtask

  task automatic load_chk(input string name, input logic [2:0] lt, input logic [1:0] off,
                          input logic [31:0] mem, input logic [31:0] exp, input logic aerr);
    issue(1'b1, 5'd3, 2'b01, lt, off, 32'h1111_1111, mem);
    tick(); hc++;
    chk(name, WriteData, exp);
    chk({name, "_aerr"}, {31'd0, align_err}, {31'd0, aerr});
    chk({name, "_we"}, {31'd0, WriteEnable}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_dest = 5'd0;
    in_wb_sel = 2'b00; in_alu_result = 32'd0; in_mem_data = 32'd0;
    in_pc_plus4 = 32'h0040_0104; in_load_type = 3'd0; in_byte_off = 2'd0;
    wb_hold = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_we", {31'd0, WriteEnable}, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_fwdv", {31'd0, fwd_valid}, 32'd0);
    chk("rst_cnt", retire_count, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic ALU writeback
    issue(1'b1, 5'd5, 2'b00, 3'd0, 2'd0, 32'h1234_5678, 32'd0);
    tick(); hc++;
    in_valid = 1'b0;
    chk("alu_we", {31'd0, WriteEnable}, 32'd1);
    chk("alu_wreg", {27'd0, WriteRegister}, 32'd5);
    chk("alu_wdata", WriteData, 32'h1234_5678);
    chk("alu_fwdv", {31'd0, fwd_valid}, 32'd1);
    chk("alu_cnt", retire_count, 32'd1);
    tick();
    chk("alu_we_off", {31'd0, WriteEnable}, 32'd0);
    chk("alu_fwd_off", {31'd0, fwd_valid}, 32'd0);

    // Sub-word loads, back to back
    load_chk("lb3",  3'd3, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0);
    load_chk("lbu1", 3'd4, 2'd1, 32'h80FF_7F01, 32'h0000_007F, 1'b0);
    load_chk("lh2",  3'd1, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0);
    load_chk("lhu2", 3'd2, 2'd2, 32'h80FF_7F01, 32'h0000_80FF, 1'b0);
    load_chk("lw1",  3'd0, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01, 1'b0);
    load_chk("lb0",  3'd3, 2'd0, 32'h80FF_7F01, 32'h0000_0001, 1'b0);
    load_chk("lh1",  3'd1, 2'd1, 32'h0000_ABCD, 32'hFFFF_ABCD, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("aerr_pulse_end", {31'd0, align_err}, 32'd0);

    // Link and reserved select
    issue(1'b1, 5'd31, 2'b10, 3'd0, 2'd0, 32'hAAAA_0000, 32'd0);
    tick(); hc++;
    chk("link", WriteData, 32'h0040_0104);
    issue(1'b1, 5'd8, 2'b11, 3'd1, 2'd1, 32'h0BAD_F00D, 32'h0000_FFFF);
    tick(); hc++;
    chk("sel11", WriteData, 32'h0BAD_F00D);
    chk("sel11_aerr", {31'd0, align_err}, 32'd0);

    // Hold: one write pulse, forward stays up, nothing accepted meanwhile
    issue(1'b1, 5'd7, 2'b00, 3'd0, 2'd0, 32'h0000_0077, 32'd0);
    tick(); hc++;
    chk("hold_we0", {31'd0, WriteEnable}, 32'd1);
    wb_hold = 1'b1;
    issue(1'b1, 5'd9, 2'b00, 3'd0, 2'd0, 32'h0000_0099, 32'd0);
    #1;
    chk("hold_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_we", {31'd0, WriteEnable}, 32'd0);
      chk("hold_fwdv", {31'd0, fwd_valid}, 32'd1);
      chk("hold_wreg", {27'd0, WriteRegister}, 32'd7);
      chk("hold_cnt", retire_count, hc);
    end
    wb_hold = 1'b0;
    tick(); hc++;
    chk("release_we", {31'd0, WriteEnable}, 32'd1);
    chk("release_wreg", {27'd0, WriteRegister}, 32'd9);
    chk("release_cnt", retire_count, hc);

    // $0 destination: counted, never written or forwarded
    issue(1'b1, 5'd0, 2'b00, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0);
    tick(); hc++;
    chk("r0_we", {31'd0, WriteEnable}, 32'd0);
    chk("r0_fwdv", {31'd0, fwd_valid}, 32'd0);
    chk("r0_cnt", retire_count, hc);

    // Three back-to-back accepts
    pulses = 0;
    for (int i = 1; i <= 3; i++) begin
      issue(1'b1, 5'(i), 2'b00, 3'd0, 2'd0, 32'h100 + 32'(i), 32'd0);
      tick(); hc++;
      if (WriteEnable) pulses++;
    end
    in_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_cnt", retire_count, hc);
    tick();

    // Flush with in_valid: nothing accepted
    issue(1'b1, 5'd6, 2'b00, 3'd0, 2'd0, 32'h6666_6666, 32'd0);
    flush = 1'b1;
    tick();
    chk("flush_we", {31'd0, WriteEnable}, 32'd0);
    chk("flush_fwdv", {31'd0, fwd_valid}, 32'd0);
    chk("flush_cnt", retire_count, hc);
    flush = 1'b0; in_valid = 1'b0;

    // Flush while HELD drops the forward tap
    issue(1'b1, 5'd10, 2'b00, 3'd0, 2'd0, 32'h0000_0010, 32'd0);
    tick(); hc++;
    in_valid = 1'b0; wb_hold = 1'b1;
    tick();
    chk("held_fwdv", {31'd0, fwd_valid}, 32'd1);
    flush = 1'b1;
    tick();
    chk("heldflush_fwdv", {31'd0, fwd_valid}, 32'd0);
    flush = 1'b0; wb_hold = 1'b0;
    tick();

    // Asynchronous reset while HELD
    issue(1'b1, 5'd4, 2'b00, 3'd0, 2'd0, 32'h4444_4444, 32'd0);
    tick();
    in_valid = 1'b0; wb_hold = 1'b1;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_fwdv", {31'd0, fwd_valid}, 32'd0);
    chk("arst_wreg", {27'd0, WriteRegister}, 32'd0);
    chk("arst_wdata", WriteData, 32'd0);
    chk("arst_cnt", retire_count, 32'd0);
    wb_hold = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
